// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register with per-cycle hold/load/shift/rotate modes
// and an autonomous burst sequencer that repeats one shift/rotate op count times.
module universal_shift_register #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  parameter int                 CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        mode,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              ser_in,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  output logic [WIDTH-1:0]  q,
  output logic              ser_out_msb,
  output logic              ser_out_lsb,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROTL = 3'b100;
  localparam logic [2:0] M_ROTR = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   data_d;
  logic [2:0]         op_q;
  logic [CNT_W-1:0]   rem_q;
  logic               busy_q;
  logic               done_q;
  logic               burst_req;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] ld,
    input logic             sin
  );
    logic [WIDTH-1:0] res;
    case (op)
      M_LOAD:  res = ld;
      M_SHL:   res = {cur[WIDTH-2:0], sin};
      M_SHR:   res = {sin, cur[WIDTH-1:1]};
      M_ROTL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ROTR:  res = {cur[0], cur[WIDTH-1:1]};
      default: res = cur;
    endcase
    return res;
  endfunction

  function automatic logic is_burst_op(input logic [2:0] m);
    return (m == M_SHL) || (m == M_SHR) || (m == M_ROTL) || (m == M_ROTR);
  endfunction

  assign burst_req = start && is_burst_op(mode);

  // The start edge of a burst only latches the op; the register is left untouched.
  always_comb begin
    data_d = data_q;
    if (state_q == BUSY) begin
      data_d = apply_op(op_q, data_q, load_data, ser_in);
    end else if (!burst_req) begin
      data_d = apply_op(mode, data_q, load_data, ser_in);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= RESET_VALUE;
      op_q    <= 3'b000;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (burst_req) begin
            op_q  <= mode;
            rem_q <= count;
            if (count != '0) begin
              busy_q  <= 1'b1;
              state_q <= BUSY;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          rem_q <= rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign q           = data_q;
  assign ser_out_msb = data_q[WIDTH-1];
  assign ser_out_lsb = data_q[0];
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
